xc_aessub_fu: RTL

Execute-stage functional unit for the XCrypto `xc.aessub.{enc,encrot,dec,decrot}` instructions. It gathers four bytes from `rs1`/`rs2` and runs them through a single shared forward/inverse AES S-box, one byte per cycle. It then returns the 32-bit result to writeback. Its `result` is the value the instruction formal spec compares against the combinational aessub checker, so both must agree bit-for-bit.

---
 rtl/xc_aessub_fu.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/xc_aessub_fu.sv
// XCrypto aessub execute unit: four gathered bytes through one shared fwd/inv AES S-box, one byte per cycle.
// Define XC_AESSUB_PARALLEL_EN for the four-S-box, zero-latency combinational variant.
module xc_aessub_fu (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    input  logic        rot,
    output logic        ready,
    output logic [31:0] result
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned N_BYTES = 4;

    // GF(2^8) multiply modulo the AES polynomial x^8+x^4+x^3+x+1
    function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                                 input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] p;
        logic [BYTE_W-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < BYTE_W; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ ({BYTE_W{x[7]}} & 8'h1b);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires)
    function automatic logic [BYTE_W-1:0] gf_inv(input logic [BYTE_W-1:0] a);
        logic [BYTE_W-1:0] r;
        logic [BYTE_W-1:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [BYTE_W-1:0] fwd_affine(input logic [BYTE_W-1:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [BYTE_W-1:0] inv_affine(input logic [BYTE_W-1:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    // Forward and inverse S-box share the field inversion; only the affine step moves
    function automatic logic [BYTE_W-1:0] sbox(input logic [BYTE_W-1:0] x,
                                               input logic              fwd);
        logic [BYTE_W-1:0] t;
        logic [BYTE_W-1:0] g;
        t = fwd ? x : inv_affine(x);
        g = gf_inv(t);
        return fwd ? fwd_affine(g) : g;
    endfunction

    logic [N_BYTES-1:0][BYTE_W-1:0] gath;
    assign gath = {rs2[31:24], rs1[23:16], rs2[15:8], rs1[7:0]};

`ifdef XC_AESSUB_PARALLEL_EN

    logic [N_BYTES-1:0][BYTE_W-1:0] u;

    for (genvar i = 0; i < N_BYTES; i++) begin : g_sbox
        assign u[i] = sbox(gath[i], enc);
    end

    assign ready  = valid;
    assign result = rot ? {u[2:0], u[3]} : u;

    logic unused_par;
    assign unused_par = ^{clock, reset, flush, rs1[31:24], rs1[15:8], rs2[23:16], rs2[7:0]};

`else

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [1:0]                     idx_q, idx_d;
    logic                           wr_en;
    logic [BYTE_W-1:0]              sbox_o;
    logic [N_BYTES-1:0][BYTE_W-1:0] res_q;

    // Operands are read live; the requester holds them until ready
    assign sbox_o = sbox(gath[idx_q], enc);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d = BUSY;
                    wr_en   = 1'b1;
                    idx_d   = idx_q + 2'd1;
                end
            end
            BUSY: begin
                wr_en = 1'b1;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            wr_en   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (wr_en) res_q[idx_q] <= sbox_o;
        end
    end

    assign ready  = (state_q == DONE);
    assign result = rot ? {res_q[2:0], res_q[3]} : res_q;

    logic unused_bits;
    assign unused_bits = ^{rs1[31:24], rs1[15:8], rs2[23:16], rs2[7:0]};

`endif

endmodule
